rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared N-bit 4-to-1 datapath mux.
- Four requesters present valid/data/last; the block grants one per beat, drives the mux select, and registers the selected word into a one-entry output stage with a valid/ready handshake.
- Packet lock: once a requester wins, it keeps the grant until its beat with last=1 is accepted.
- Sits between producer channels and a single downstream consumer.

Parameters:
- N, 32, data width in bits of each input word and of out_data.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  4  bit i: requester i has a word on in_data_i
- in_last  in  4  bit i: current word of requester i ends its packet
- in_data_0 .. in_data_3  in  N (each)  requester data words
- in_ready  out  4  bit i: word from requester i is accepted this cycle; one-hot or zero
- out_valid  out  1  output register holds a word
- out_data  out  N  registered selected word
- out_last  out  1  registered last flag of that word
- out_sel  out  2  registered index of the requester that supplied out_data
- out_ready  in  1  consumer accepts out_data this cycle

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - State=ARB, rr pointer=0, lock owner=0.
  - Any packet in flight is abandoned.
  - in_ready=0 while rst=1.
- Accept slot: can_load = !out_valid || out_ready.
- State ARB (no lock):
  - Winner = first i with in_valid[i], searching pointer, pointer+1, ... mod 4.
  - If can_load and any valid: in_ready[winner]=1 (combinational) and the word is loaded at the edge.
    - out_data=in_data_winner, out_last=in_last[winner], out_sel=winner, out_valid=1.
    - Pointer <= winner+1 mod 4.
    - If in_last[winner]=0: go LOCKED with owner=winner.
  - No valid, or !can_load: in_ready=0, no state change.
- State LOCKED:
  - Only the owner is eligible. in_ready[owner] = can_load && in_valid[owner]; all others 0.
  - Owner with valid low: hold the lock, no grant to others, no timeout.
  - Accepted owner beat with last=1: return to ARB. Pointer is already owner+1.
- Output stage:
  - If out_valid && out_ready and nothing loads: out_valid <= 0.
  - Load and drain in the same cycle is allowed, giving 1 word/cycle sustained throughput.
  - out_data/out_last/out_sel hold stable while out_valid && !out_ready.
- Latency: 1 cycle from accept (in_ready&in_valid) to out_valid.
- Combinational paths: in_valid -> in_ready and out_ready -> in_ready exist; none to out_*.
- in_ready never depends on in_data.
- Fairness: under continuous single-beat requests from all four, grant order is 0,1,2,3,0...
- No requester waits more than 3 packets.
- Pointer wrap: 3 -> 0.
- Single requester: it is granted every cycle that can_load holds.

Decomposition:
- Package rr_mux4_pkg holds:
  - localparam NUM_REQ=4 and SEL_W=2.
  - typedef enum logic {ARB, LOCKED} arb_state_t.
- Sub-module rr_pick4: combinational rotate-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
- Data select: a case on the winning index inside this block.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'hF -> in_ready=0, out_valid=0, out_sel=0 throughout; after release, first grant goes to requester 0.
- Rotation: all valid, all last=1, in_data_i=32'hA+i, out_ready=1 -> out_data sequence A,B,C,D,A with out_sel 0,1,2,3,0, one per cycle after 1-cycle latency.
- Packet lock:
  - Stimulus: requester 2 sends 3 beats (last on the third) while 0, 1 and 3 stay valid.
  - Required: out_sel=2 for 3 consecutive words, then requester 3 is granted next, then 0.
- Backpressure: out_ready=0 for 4 cycles with word 32'h5 pending -> out_data stays 32'h5, in_ready=0; out_ready=1 -> next word loads in the same cycle out_data drains.
- Lock stall:
  - Stimulus: owner 1 drops valid mid-packet for 3 cycles while 0 stays valid.
  - Required: in_ready=0 for those cycles; resumes with out_sel=1 when owner 1 is valid again.
- Reset mid-packet: assert rst while LOCKED to requester 3 -> next grant after reset goes to requester 0; no stale out_valid remains.

Source files
------------

// File: rtl/rr_mux4_pkg.sv
// Shared constants and state type for the 4-way round-robin mux arbiter.
package rr_mux4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {ARB, LOCKED} arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping 3 -> 0.
module rr_pick4
    import rr_mux4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with packet lock driving a 4:1 data mux into a one-entry output register.
//   state  | meaning
//   ARB    | no packet open; rotating-priority pick among valid requesters
//   LOCKED | owner mid-packet; only owner may be granted until its last beat
module rr_mux4_arbiter
    import rr_mux4_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] in_valid,
    input  logic [NUM_REQ-1:0] in_last,
    input  logic [N-1:0]       in_data_0,
    input  logic [N-1:0]       in_data_1,
    input  logic [N-1:0]       in_data_2,
    input  logic [N-1:0]       in_data_3,
    output logic [NUM_REQ-1:0] in_ready,
    output logic               out_valid,
    output logic [N-1:0]       out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] owner;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             can_load;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic [N-1:0]     sel_data;
    logic             sel_last;

    rr_pick4 u_pick (
        .req (in_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        can_load  = !out_valid || out_ready;
        grant_any = pick_any;
        grant_idx = pick_idx;
        if (state == LOCKED) begin
            grant_any = in_valid[owner];
            grant_idx = owner;
        end
        load     = !rst && can_load && grant_any;
        in_ready = load ? (NUM_REQ'(1) << grant_idx) : '0;
        sel_last = in_last[grant_idx];
        case (grant_idx)
            2'd0:    sel_data = in_data_0;
            2'd1:    sel_data = in_data_1;
            2'd2:    sel_data = in_data_2;
            default: sel_data = in_data_3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_sel   <= grant_idx;
                if (state == ARB) begin
                    // pointer moves only on a fresh win, so it already sits at owner+1 when the lock ends
                    ptr <= grant_idx + 2'd1;
                    if (!sel_last) begin
                        state <= LOCKED;
                        owner <= grant_idx;
                    end
                end else if (sel_last) begin
                    state <= ARB;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: expected words go to a scoreboard queue, a monitor checks each accepted output.
module tb_rr_mux4_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [31:0] in_data_0, in_data_1, in_data_2, in_data_3;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    rr_mux4_arbiter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data_0 (in_data_0),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_data_3 (in_data_3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.last = l;
        e.sel  = s;
        q.push_back(e);
    endtask

    task automatic chk_ready(input string name, input logic [3:0] exp);
        @(negedge clk);
        chk(name, {60'd0, in_ready}, {60'd0, exp});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d words still expected, required 0", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%0h last=%0b sel=%0d, required none",
                             out_data, out_last, out_sel);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.data || out_last !== e.last || out_sel !== e.sel) begin
                        errors++;
                        $display("FAIL out_word: got data=%0h last=%0b sel=%0d, required data=%0h last=%0b sel=%0d",
                                 out_data, out_last, out_sel, e.data, e.last, e.sel);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 4'hF;
        in_last = 4'hF;
        in_data_0 = 32'hA;
        in_data_1 = 32'hB;
        in_data_2 = 32'hC;
        in_data_3 = 32'hD;
        out_ready = 1'b1;
        step();

        // reset held with all requesters valid
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_sel", {62'd0, out_sel}, 64'd0);
            step();
        end

        // rotation: grants 0,1,2,3,0
        rst = 1'b0;
        push(32'hA, 1'b1, 2'd0);
        push(32'hB, 1'b1, 2'd1);
        push(32'hC, 1'b1, 2'd2);
        push(32'hD, 1'b1, 2'd3);
        push(32'hA, 1'b1, 2'd0);
        for (int k = 0; k < 5; k++) begin
            chk_ready("rot_in_ready", 4'b0001 << (k % 4));
            step();
        end
        in_valid = 4'h0;
        wait_drain("rotation");

        // packet lock: pointer is 1; one beat from 1 moves it to 2, then 2 sends a 3-beat packet
        in_data_0 = 32'h40;
        in_data_1 = 32'h11;
        in_data_3 = 32'h30;
        in_valid = 4'b0010;
        in_last = 4'hF;
        push(32'h11, 1'b1, 2'd1);
        push(32'h21, 1'b0, 2'd2);
        push(32'h22, 1'b0, 2'd2);
        push(32'h23, 1'b1, 2'd2);
        push(32'h30, 1'b1, 2'd3);
        push(32'h40, 1'b1, 2'd0);
        chk_ready("lock_first", 4'b0010);
        step();
        in_valid = 4'hF;
        in_last = 4'b1011;
        in_data_2 = 32'h21;
        chk_ready("lock_beat1", 4'b0100);
        step();
        in_data_2 = 32'h22;
        chk_ready("lock_beat2", 4'b0100);
        step();
        in_data_2 = 32'h23;
        in_last = 4'hF;
        chk_ready("lock_beat3", 4'b0100);
        step();
        in_valid = 4'b1011;
        chk_ready("lock_next3", 4'b1000);
        step();
        chk_ready("lock_next0", 4'b0001);
        step();
        in_valid = 4'h0;
        wait_drain("lock");

        // backpressure: pointer is 1; word 5 from requester 1 then held for 4 cycles
        in_valid = 4'b0010;
        in_data_1 = 32'h5;
        push(32'h5, 1'b1, 2'd1);
        push(32'h6, 1'b1, 2'd2);
        chk_ready("bp_load", 4'b0010);
        step();
        in_valid = 4'b0100;
        in_data_2 = 32'h6;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {60'd0, in_ready}, 64'd0);
            chk("bp_out_data", {32'd0, out_data}, 64'h5);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            step();
        end
        out_ready = 1'b1;
        chk_ready("bp_release", 4'b0100);
        step();
        in_valid = 4'h0;
        wait_drain("backpressure");

        // lock stall: pointer is 3; owner 1 opens a packet then drops valid while 0 waits
        in_valid = 4'b0010;
        in_last = 4'b1101;
        in_data_1 = 32'h51;
        in_data_0 = 32'h60;
        push(32'h51, 1'b0, 2'd1);
        push(32'h52, 1'b1, 2'd1);
        push(32'h60, 1'b1, 2'd0);
        chk_ready("stall_open", 4'b0010);
        step();
        in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            chk_ready("stall_in_ready", 4'b0000);
            step();
        end
        in_valid = 4'b0011;
        in_last = 4'hF;
        in_data_1 = 32'h52;
        chk_ready("stall_resume", 4'b0010);
        step();
        in_valid = 4'b0001;
        chk_ready("stall_after", 4'b0001);
        step();
        in_valid = 4'h0;
        wait_drain("stall");

        // reset mid-packet: pointer is 1; requester 3 locks, its word is left pending
        in_valid = 4'b1000;
        in_last = 4'b0111;
        in_data_3 = 32'h71;
        out_ready = 1'b0;
        chk_ready("mid_lock3", 4'b1000);
        step();
        rst = 1'b1;
        in_valid = 4'hF;
        in_last = 4'hF;
        in_data_0 = 32'h80;
        chk_ready("mid_rst_in_ready", 4'b0000);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'h80, 1'b1, 2'd0);
        @(negedge clk);
        chk("mid_no_stale", {63'd0, out_valid}, 64'd0);
        chk("mid_first_grant", {60'd0, in_ready}, 64'b0001);
        step();
        in_valid = 4'h0;
        wait_drain("reset_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
